// File: rtl/shifter_seq_pkg.sv
// Shared types and constants for the shifter DE/LOAD sequencer:
// FSM state encoding, LOAD strobe timing and the wakestate start-offset table.
package shifter_seq_pkg;

  localparam int LOAD_PERIOD    = 16;
  localparam int LOAD_LOW       = 4;
  localparam int PHASE_W        = $clog2(LOAD_PERIOD);
  localparam int WAKE_W         = 5;
  localparam int MAX_WAKE_DELAY = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_BLANK,
    ST_WAKE,
    ST_ACTIVE
  } seq_state_e;

  // Clocks spent in WAKE before the first active LOAD period begins.
  function automatic logic [WAKE_W-1:0] wake_delay(input logic [1:0] wakestate);
    unique case (wakestate)
      2'd0:    wake_delay = WAKE_W'(24);
      2'd1:    wake_delay = WAKE_W'(12);
      2'd2:    wake_delay = WAKE_W'(20);
      default: wake_delay = WAKE_W'(16);
    endcase
  endfunction

endpackage

// File: rtl/shifter_load_sequencer_if.sv
// Fetch-source handshake: the source presents word_valid/word_data and
// the sequencer answers with a one-cycle word_ready pop strobe.
interface shifter_load_sequencer_if;

  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/shifter_load_phase.sv
// Free-running LOAD_PERIOD phase counter shared by PRIME and ACTIVE; decodes the
// active-low load window, the pop phase just before it and the last phase.
module shifter_load_phase
  import shifter_seq_pkg::*;
(
  input  logic CLOCK_32,
  input  logic reset,
  input  logic run,
  output logic load,
  output logic pop,
  output logic done
);

  localparam logic [PHASE_W-1:0] LOW_FIRST  = PHASE_W'(LOAD_PERIOD - LOAD_LOW);
  localparam logic [PHASE_W-1:0] POP_PHASE  = PHASE_W'(LOAD_PERIOD - LOAD_LOW - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(LOAD_PERIOD - 1);

  logic [PHASE_W-1:0] phase;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_32) begin
    if (reset || !run) begin
      phase <= '0;
    end else if (phase == LAST_PHASE) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign load = !(run && (phase >= LOW_FIRST));
  assign pop  = run && (phase == POP_PHASE);
  assign done = run && (phase == LAST_PHASE);

endmodule

// File: rtl/shifter_load_sequencer.sv
// Drives the video shifter's DE, LOAD and data bus from the fetch FIFO.
// Optional macro UNDERRUN_CNT_EN adds a saturating underrun_count output.
module shifter_load_sequencer
  import shifter_seq_pkg::*;
#(
  parameter int LINE_CLKS    = 2048,
  parameter int DE_START     = 256,
  parameter int ACTIVE_WORDS = 80,
  parameter int PRIME_LOADS  = 3
) (
  input  logic                     CLOCK_32,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               wakestate,
  shifter_load_sequencer_if.slave  fetch,
  output logic                     de,
  output logic                     load,
  output logic [15:0]              data,
  output logic                     data_oe,
  output logic                     line_start,
  output logic                     underrun
`ifdef UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_count
`endif
);

  localparam int LINE_W = $clog2(LINE_CLKS);
  localparam int CNT_MAX = (ACTIVE_WORDS > PRIME_LOADS) ? ACTIVE_WORDS : PRIME_LOADS;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(LINE_CLKS - 1);
  localparam logic [LINE_W-1:0] WAKE_CHECK  = LINE_W'(DE_START - 1);
  localparam logic [CNT_W-1:0]  PRIME_LAST  = CNT_W'(PRIME_LOADS - 1);
  localparam logic [CNT_W-1:0]  ACTIVE_LAST = CNT_W'(ACTIVE_WORDS - 1);

  if (DE_START + MAX_WAKE_DELAY + LOAD_PERIOD * ACTIVE_WORDS >= LINE_CLKS) begin : g_bad_line
    $error("shifter_load_sequencer: active window does not fit inside LINE_CLKS");
  end
  if ((ACTIVE_WORDS % 4) != 0 || ACTIVE_WORDS < 4) begin : g_bad_words
    $error("shifter_load_sequencer: ACTIVE_WORDS must be a non-zero multiple of 4");
  end
  if (DE_START < 1 || PRIME_LOADS < 1) begin : g_bad_start
    $error("shifter_load_sequencer: DE_START and PRIME_LOADS must be at least 1");
  end

  seq_state_e         state, state_next;
  logic [LINE_W-1:0]  line_cnt;
  logic [CNT_W-1:0]   strobe_cnt;
  logic [WAKE_W-1:0]  wake_cnt;
  logic [15:0]        data_q;
  logic               oe_q;
  logic               run, pop, done;

  assign run = (state == ST_PRIME) || (state == ST_ACTIVE);

  shifter_load_phase u_phase (
    .CLOCK_32 (CLOCK_32),
    .reset    (reset),
    .run      (run),
    .load     (load),
    .pop      (pop),
    .done     (done)
  );

  // BLANK leaves one clock early so DE is already high when the counter reads DE_START.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_next = state;
    de         = 1'b0;
    data_oe    = oe_q;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        de      = 1'b1;
        data_oe = 1'b1;
        if (done && strobe_cnt == PRIME_LAST) state_next = ST_BLANK;
      end
      ST_BLANK: begin
        if (line_cnt == WAKE_CHECK) state_next = enable ? ST_WAKE : ST_IDLE;
      end
      ST_WAKE: begin
        de = 1'b1;
        if (wake_cnt == '0) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        de = 1'b1;
        if (done && strobe_cnt == ACTIVE_LAST) state_next = ST_BLANK;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fetch.word_ready = (state == ST_ACTIVE) && pop && fetch.word_valid;
  assign underrun         = (state == ST_ACTIVE) && pop && !fetch.word_valid;
  assign line_start       = (state != ST_IDLE) && (line_cnt == '0);
  assign data             = data_q;

  always_ff @(posedge CLOCK_32) begin
    if (reset) begin
      state      <= ST_IDLE;
      line_cnt   <= '0;
      strobe_cnt <= '0;
      wake_cnt   <= '0;
      data_q     <= '0;
      oe_q       <= 1'b0;
    end else begin
      state <= state_next;

      if (state == ST_IDLE || state_next == ST_IDLE ||
          (state == ST_PRIME && state_next == ST_BLANK) || line_cnt == LINE_LAST) begin
        line_cnt <= '0;
      end else begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (state_next != state) begin
        strobe_cnt <= '0;
      end else if (done) begin
        strobe_cnt <= strobe_cnt + 1'b1;
      end

      if (state == ST_BLANK && state_next == ST_WAKE) begin
        wake_cnt <= wake_delay(wakestate) - 1'b1;
      end else if (state == ST_WAKE && wake_cnt != '0) begin
        wake_cnt <= wake_cnt - 1'b1;
      end

      // A missing word loads zero so the shifter's plane counter stays aligned.
      if (state == ST_ACTIVE && pop) begin
        data_q <= fetch.word_valid ? fetch.word_data : 16'h0000;
      end else if (state != ST_ACTIVE) begin
        data_q <= '0;
      end

      oe_q <= (state_next == ST_ACTIVE) && (oe_q || (state == ST_ACTIVE && pop));
    end
  end

`ifdef UNDERRUN_CNT_EN
  always_ff @(posedge CLOCK_32) begin
    if (reset || (state_next == ST_IDLE && state != ST_IDLE)) begin
      underrun_count <= '0;
    end else if (underrun && underrun_count != 8'hFF) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`endif

endmodule
